// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe -- 2-stage pipelined barrel shifter with N/Z/C/V flags.
//
// Modes (op): 00 LSL, 01 LSR, 10 ASR, 11 ROR.
// Optional feature macro: SHIFT_ROR_EN
//   defined   : op=11 rotates right by B mod M.
//   undefined : op=11 passes A through (R=A, C=0, V=0); no rotate logic is built.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   in_valid/in_ready      operand handshake (A shiftee, B amount, op mode)
//   out_valid/out_ready    result handshake (R result, C/N/V/Z flags)
//
// Datapath trick: every shift works on a 2M-bit window so the bits that fall
// off the M-bit result are kept next to it. The carry is then simply the
// window bit adjacent to the result field. Stage 1 shifts by the middle amount
// bits B[SW-2:SW/2]; stage 2 shifts by the top bit (weight M) plus the low bits.
module shift_unit_pipe #(
  parameter int M  = 8,
  parameter int SW = $clog2(M) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  A,
  input  logic [SW-1:0] B,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  R,
  output logic          C,
  output logic          N,
  output logic          V,
  output logic          Z
);

  localparam int LO = SW / 2;
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

`ifdef SHIFT_ROR_EN
  function automatic logic [M-1:0] rotr(input logic [M-1:0] x, input logic [SW-2:0] s);
    logic [2*M-1:0] t;
    t = {x, x} >> s;
    return t[M-1:0];
  endfunction
`endif

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1 ----------------
  logic [SW-2:0]  amt1;
  logic [2*M-1:0] w1_d, w1_q;
  logic [M-1:0]   a1_q;
  logic [SW-1:0]  b1_q;
  logic [1:0]     op1_q;

  assign amt1 = {B[SW-2:LO], {LO{1'b0}}};

  always_comb begin
    w1_d = {A, {M{1'b0}}};
    case (op)
      OP_LSL:  w1_d = {{M{1'b0}}, A} << amt1;
      OP_LSR:  w1_d = {A, {M{1'b0}}} >> amt1;
      OP_ASR:  w1_d = $signed({A, {M{1'b0}}}) >>> amt1;
`ifdef SHIFT_ROR_EN
      // rotation stays inside the low M bits of the window
      default: w1_d = {{M{1'b0}}, rotr(A, amt1)};
`else
      default: w1_d = {A, {M{1'b0}}};
`endif
    endcase
  end

  // ---------------- stage 2 (combinational part) ----------------
  logic [SW-1:0]  amt2;
  logic [2*M-1:0] w2;
  logic [2*M-1:0] sx, p;
  logic           lsl_ovf;
  logic [M-1:0]   r_d;
  logic           c_d, v_d;

  // remaining amount: top bit (weight M) plus the low bits
  assign amt2 = {b1_q[SW-1], {(SW-1-LO){1'b0}}, b1_q[LO-1:0]};

  // LSL overflow: sign-extend A, shift, and require every bit from the
  // result sign upward to agree. Any non-zero A overflows once k >= M.
  assign sx      = {{M{a1_q[M-1]}}, a1_q};
  assign p       = sx << b1_q[SW-2:0];
  assign lsl_ovf = b1_q[SW-1] ? (|a1_q) : (p[2*M-1:M-1] != {(M+1){p[M-1]}});

  always_comb begin
    w2  = w1_q;
    r_d = w1_q[2*M-1:M];
    c_d = 1'b0;
    v_d = 1'b0;
    case (op1_q)
      OP_LSL: begin
        w2  = w1_q << amt2;
        r_d = w2[M-1:0];
        c_d = w2[M];
        v_d = lsl_ovf;
      end
      OP_LSR: begin
        w2  = w1_q >> amt2;
        r_d = w2[2*M-1:M];
        c_d = w2[M-1];
      end
      OP_ASR: begin
        w2  = $signed(w1_q) >>> amt2;
        r_d = w2[2*M-1:M];
        c_d = w2[M-1];
      end
      default: begin
`ifdef SHIFT_ROR_EN
        r_d = rotr(w1_q[M-1:0], (SW-1)'(b1_q[LO-1:0]));
        c_d = (b1_q != '0) & r_d[M-1];
`else
        r_d = w1_q[2*M-1:M];
`endif
      end
    endcase
  end

  // ---------------- registers ----------------
  logic [M-1:0] r_q;
  logic         c_q, n_q, v_q, z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      w1_q       <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      op1_q      <= '0;
      r_q        <= '0;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        w1_q  <= w1_d;
        a1_q  <= A;
        b1_q  <= B;
        op1_q <= op;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      // output registers only move on advance, so a stalled beat holds still
      if (s2_adv && s1_valid_q) begin
        r_q <= r_d;
        c_q <= c_d;
        n_q <= r_d[M-1];
        v_q <= v_d;
        z_q <= ~|r_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign R         = r_q;
  assign C         = c_q;
  assign N         = n_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe (M=8). Expected beats are queued when
// an input transfer is seen and compared when an output transfer occurs.
// Works with SHIFT_ROR_EN defined or undefined.
module tb_shift_unit_pipe;
  localparam int M  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [M-1:0]  A, R;
  logic [SW-1:0] B;
  logic [1:0]    op;
  logic          C, N, V, Z;

  logic ordy_dir, rnd_mode, lat_chk;
  logic ordy_rnd = 1'b1;
  int   n_vec = 0, n_err = 0, cyc = 0, lt;
  logic [11:0] q[$];
  int          lq[$];
  logic        hold_v = 1'b0;
  logic [11:0] hold_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin #1; ordy_rnd = ($urandom_range(0, 3) != 0); end
  assign out_ready = rnd_mode ? ordy_rnd : ordy_dir;

  shift_unit_pipe #(.M(M), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .C(C), .N(N), .V(V), .Z(Z)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: {R, C, N, V, Z}
  function automatic logic [11:0] model(logic [M-1:0] a, logic [SW-1:0] b, logic [1:0] o);
    int k;
    logic [M-1:0] r;
    logic c, v;
    k = int'(b); r = a; c = 1'b0; v = 1'b0;
    case (o)
      2'd0: begin
        r = (k >= M) ? '0 : a << k;
        if (k > 0 && k <= M) c = a[M-k];
        if (k >= M) v = (a != 0);
        else for (int i = M-1-k; i < M-1; i++) if (a[i] != a[M-1]) v = 1'b1;
      end
      2'd1: begin
        r = (k >= M) ? '0 : a >> k;
        if (k > 0 && k <= M) c = a[k-1];
      end
      2'd2: begin
        if (k >= M) begin r = {M{a[M-1]}}; c = a[M-1]; end
        else begin
          for (int i = 0; i < M; i++) r[i] = (i + k < M) ? a[i+k] : a[M-1];
          if (k > 0) c = a[k-1];
        end
      end
      default: begin
`ifdef SHIFT_ROR_EN
        for (int i = 0; i < M; i++) r[i] = a[(i + k) % M];
        c = (k != 0) && r[M-1];
`else
        r = a;
`endif
      end
    endcase
    return {r, c, r[M-1], v, (r == '0)};
  endfunction

  task automatic send(logic [M-1:0] a, logic [SW-1:0] b, logic [1:0] o,
                      logic use_exp, logic [11:0] e);
    bit ok = 0;
    A = a; B = b; op = o; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok) begin
      q.push_back(use_exp ? e : model(a, b, o));
      lq.push_back(cyc);
    end else chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // output monitor
  always @(negedge clk) begin
    if (rst) hold_v = 1'b0;
    else begin
      if (hold_v) chk("held_beat", {out_valid, R, C, N, V, Z}, {1'b1, hold_d});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("result", {R, C, N, V, Z}, q.pop_front());
          lt = lq.pop_front();
          if (lat_chk) chk("latency", cyc - lt, 2);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = {R, C, N, V, Z};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = '0;
    ordy_dir = 1'b1; rnd_mode = 1'b0; lat_chk = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {R, C, N, V, Z}, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // modes back-to-back, A=0x96, then boundaries
    lat_chk = 1'b1;
    send(8'h96, 4'd1, 2'd0, 1, {8'h2C, 4'b1010});
    send(8'h96, 4'd3, 2'd1, 1, {8'h12, 4'b1000});
    send(8'h96, 4'd2, 2'd2, 1, {8'hE5, 4'b1100});
`ifdef SHIFT_ROR_EN
    send(8'h96, 4'd4, 2'd3, 1, {8'h69, 4'b0000});
`else
    send(8'h96, 4'd4, 2'd3, 1, {8'h96, 4'b0100});
`endif
    send(8'h96, 4'd8,  2'd0, 1, {8'h00, 4'b0011});
    send(8'h80, 4'd8,  2'd1, 1, {8'h00, 4'b1001});
    send(8'h80, 4'd12, 2'd2, 1, {8'hFF, 4'b1100});
    for (int o = 0; o < 4; o++) send(8'hA5, 4'd0, 2'(o), 1, {8'hA5, 4'b0100});
    send(8'h00, 4'd3, 2'd3, 1, {8'h00, 4'b0001});
    idle(4);
    lat_chk = 1'b0;
    chk("drain_directed", q.size(), 0);

    // backpressure: two beats fill the pipe, third waits while stalled
    ordy_dir = 1'b0;
    send(8'h3C, 4'd1, 2'd0, 0, '0);
    send(8'h3C, 4'd2, 2'd1, 0, '0);
    A = 8'hC3; B = 4'd5; op = 2'd2; in_valid = 1'b1;
    repeat (3) begin @(negedge clk); chk("in_ready_stalled", in_ready, 0); end
    @(posedge clk); #1;
    ordy_dir = 1'b1; in_valid = 1'b0;
    send(8'hC3, 4'd5, 2'd2, 0, '0);
    send(8'hC3, 4'd6, 2'd3, 0, '0);
    idle(4);
    chk("drain_backpressure", q.size(), 0);

    // asynchronous reset with two beats in flight
    send(8'h5A, 4'd1, 2'd0, 0, '0);
    send(8'h5A, 4'd2, 2'd1, 0, '0);
    #2 rst = 1'b1;
    q.delete(); lq.delete();
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_outputs", {R, C, N, V, Z}, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_release_in_ready", in_ready, 1);
    repeat (3) begin @(negedge clk); chk("no_stale_beat", out_valid, 0); end
    @(posedge clk); #1;

    // random stream with random backpressure and input gaps
    rnd_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(M'($urandom), SW'($urandom), 2'($urandom), 0, '0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rnd_mode = 1'b0;
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    #1 chk("final_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
